// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM arbiter and its refresh scheduler.
// Holds the FSM state enum, bus widths and the default timing parameters.
package sdram_pkg;

  localparam int ADDR_W               = 22;
  localparam int DATA_W               = 16;
  localparam int ACCESS_LEN_DEF       = 8;
  localparam int REFRESH_INTERVAL_DEF = 480;
  localparam int REFRESH_GAP_DEF      = 3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_REFRESH
  } state_t;

  // Fields presented to the controller for one access slot
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        ds;
    logic [DATA_W-1:0] din;
  } mem_cmd_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh scheduler: down-counter plus a saturating count of owed refreshes.
// pending is combinational from registers, so an expiry is visible the same cycle; no backpressure.
module sdram_refresh_timer import sdram_pkg::*; #(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic take,
  output logic pending
);

  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    ref_pend;
  logic          expire;

  assign expire  = enable && (cnt == '0);
  assign pending = expire || (ref_pend != 2'd0);

  // While disabled the schedule restarts from scratch: a reinitialised controller owes nothing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= RELOAD;
      ref_pend <= 2'd0;
    end else if (!enable) begin
      cnt      <= RELOAD;
      ref_pend <= 2'd0;
    end else begin
      cnt <= expire ? RELOAD : cnt - 1'b1;
      case ({expire, take})
        2'b10:   if (ref_pend != 2'd3) ref_pend <= ref_pend + 2'd1;
        2'b01:   if (ref_pend != 2'd0) ref_pend <= ref_pend - 2'd1;
        default: ref_pend <= ref_pend;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client round-robin sequencer with refresh priority in front of the SDRAM controller.
// Request seen in IDLE at N: cs high N+1..N+8, ack at N+9; clients wait on level req until ack.
module sdram_arbiter import sdram_pkg::*; #(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int ACCESS_LEN       = ACCESS_LEN_DEF,
  parameter int REFRESH_GAP      = REFRESH_GAP_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_ds,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [1:0]        c0_ds,
  input  logic [DATA_W-1:0] c0_din,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [1:0]        c1_ds,
  input  logic [DATA_W-1:0] c1_din,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata
);

  localparam int SPAN  = (ACCESS_LEN > REFRESH_GAP + 1) ? ACCESS_LEN : REFRESH_GAP + 1;
  localparam int CNT_W = $clog2(SPAN + 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_LEN - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_GAP);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              cs_q, cs_d;
  logic              refresh_q, refresh_d;
  logic              grantee_q, grantee_d;
  logic              last_q, last_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              take, pending;
  logic              elig0, elig1, pick, arb_ok;
  mem_cmd_t          req_cmd0, req_cmd1;

  assign req_cmd0 = '{we: c0_we, addr: c0_addr, ds: c0_ds, din: c0_din};
  assign req_cmd1 = '{we: c1_we, addr: c1_addr, ds: c1_ds, din: c1_din};

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_q != ST_INIT),
    .take    (take),
    .pending (pending)
  );

  // The client being acked in GAP sits out, so a held request cannot starve the other one
  always_comb begin
    elig0 = c0_req && !(state_q == ST_GAP && grantee_q == 1'b0);
    elig1 = c1_req && !(state_q == ST_GAP && grantee_q == 1'b1);
    pick  = (elig0 && elig1) ? ~last_q : elig1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    cs_d      = cs_q;
    refresh_d = refresh_q;
    grantee_d = grantee_q;
    last_d    = last_q;
    ack_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    take      = 1'b0;
    arb_ok    = 1'b0;

    case (state_q)
      ST_INIT: begin
        cmd_d     = '0;
        cs_d      = 1'b0;
        refresh_d = 1'b0;
        if (mem_ready) state_d = ST_IDLE;
      end
      ST_IDLE: arb_ok = 1'b1;
      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ACC_LAST) begin
          if (!cmd_q.we) begin
            if (grantee_q) rdata1_d = mem_dout;
            else           rdata0_d = mem_dout;
          end
          ack_d[grantee_q] = 1'b1;
          cs_d     = 1'b0;
          cmd_d.we = 1'b0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        arb_ok  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_REFRESH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          take      = 1'b1;
          cs_d      = 1'b0;
          refresh_d = 1'b0;
        end
        if (cnt_q == REF_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    if (arb_ok) begin
      if (pending) begin
        state_d   = ST_REFRESH;
        cnt_d     = '0;
        cs_d      = 1'b1;
        refresh_d = 1'b1;
        cmd_d.we  = 1'b0;
      end else if (elig0 || elig1) begin
        state_d   = ST_ACCESS;
        cnt_d     = '0;
        cs_d      = 1'b1;
        refresh_d = 1'b0;
        cmd_d     = pick ? req_cmd1 : req_cmd0;
        grantee_d = pick;
        last_d    = pick;
      end
    end

    // Losing the controller abandons whatever is in flight, without ack or data
    if (state_q != ST_INIT && !mem_ready) begin
      state_d   = ST_INIT;
      cmd_d     = '0;
      cs_d      = 1'b0;
      refresh_d = 1'b0;
      ack_d     = 2'b00;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      take      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      cmd_q     <= '0;
      cs_q      <= 1'b0;
      refresh_q <= 1'b0;
      grantee_q <= 1'b0;
      last_q    <= 1'b1;
      ack_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      cs_q      <= cs_d;
      refresh_q <= refresh_d;
      grantee_q <= grantee_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign mem_cs      = cs_q;
  assign mem_we      = cmd_q.we;
  assign mem_refresh = refresh_q;
  assign mem_addr    = cmd_q.addr;
  assign mem_ds      = cmd_q.ds;
  assign mem_din     = cmd_q.din;
  assign c0_ack      = ack_q[0];
  assign c1_ack      = ack_q[1];
  assign c0_rdata    = rdata0_q;
  assign c1_rdata    = rdata1_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; memory model returns addr[15:0] ^ 16'h9DAA.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              mem_ready;
  logic              mem_cs, mem_we, mem_refresh;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_ds;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              c0_req, c0_we, c1_req, c1_we;
  logic [ADDR_W-1:0] c0_addr, c1_addr;
  logic [1:0]        c0_ds, c1_ds;
  logic [DATA_W-1:0] c0_din, c1_din;
  logic              c0_ack, c1_ack;
  logic [DATA_W-1:0] c0_rdata, c1_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  localparam logic [ADDR_W-1:0] A0 = 22'h000111;  // reads back 16'h9CBB
  localparam logic [ADDR_W-1:0] A1 = 22'h2A0222;  // reads back 16'h9F88

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_dout = mem_addr[15:0] ^ 16'h9DAA;

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .mem_ready(mem_ready),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_ds(mem_ds), .mem_din(mem_din), .mem_dout(mem_dout),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_ds(c0_ds), .c0_din(c0_din),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_ds(c1_ds), .c1_din(c1_din),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b0;
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_ds = 2'b11; c0_din = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_ds = 2'b11; c1_din = '0;
    repeat (3) tick();
    n_cmp++;
    if ({mem_cs, mem_we, mem_refresh, c0_ack, c1_ack} !== 5'b0 || mem_addr !== '0 ||
        mem_ds !== 2'b0 || mem_din !== '0 || c0_rdata !== '0 || c1_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: cs=%b we=%b ref=%b addr=%h ds=%b din=%h r0=%h r1=%h, all must be 0",
               mem_cs, mem_we, mem_refresh, mem_addr, mem_ds, mem_din, c0_rdata, c1_rdata);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_init_refresh();
    int r;
    logic quiet;
    quiet = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if ({mem_cs, mem_we, mem_refresh, c0_ack, c1_ack} !== 5'b0 || mem_addr !== '0) quiet = 1'b0;
      if (i == 10) mem_ready = 1'b1;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL init_quiet: outputs active before mem_ready, required 0"); end
    r = cyc;
    tick();
    n_cmp++;
    if ({mem_cs, mem_we, mem_refresh} !== 3'b0) begin
      n_bad++; $display("FAIL idle_first_cycle: cs/we/ref=%b%b%b required 000", mem_cs, mem_we, mem_refresh);
    end
    quiet = 1'b1;
    for (int k = 2; k <= 480; k++) begin
      tick();
      if (mem_cs !== 1'b0 || mem_refresh !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL refresh_early: cs rose before cycle 480 after IDLE"); end
    tick();
    t0 = r + 481;
    n_cmp++;
    if (mem_cs !== 1'b1 || mem_refresh !== 1'b1 || mem_we !== 1'b0) begin
      n_bad++; $display("FAIL first_refresh: cs=%b ref=%b we=%b required 1 1 0", mem_cs, mem_refresh, mem_we);
    end
    quiet = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (mem_cs !== 1'b0 || mem_refresh !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin n_bad++; $display("FAIL refresh_gap: cs/ref active in gap, required 0"); end
  endtask

  task automatic test_read_c0();
    logic ok;
    wait_until(t0 + 6);
    n_cmp++;
    if (mem_cs !== 1'b0) begin n_bad++; $display("FAIL read_pre_idle: cs=%b required 0", mem_cs); end
    c0_req = 1; c0_we = 0; c0_addr = 22'h012345; c0_ds = 2'b11;
    ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_refresh !== 1'b0 ||
          mem_addr !== 22'h012345 || mem_ds !== 2'b11 || c0_ack !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL read_slot: cs/addr not held for 8 cycles, addr=%h required 012345", mem_addr); end
    tick();
    n_cmp++;
    if (c0_ack !== 1'b1 || mem_cs !== 1'b0 || c0_rdata !== 16'hBEEF) begin
      n_bad++; $display("FAIL read_ack: ack=%b cs=%b rdata=%h required 1 0 beef", c0_ack, mem_cs, c0_rdata);
    end
    c0_req = 0;
    tick();
    n_cmp++;
    if (c0_ack !== 1'b0 || mem_cs !== 1'b0 || c0_rdata !== 16'hBEEF) begin
      n_bad++; $display("FAIL read_after: ack=%b cs=%b rdata=%h required 0 0 beef", c0_ack, mem_cs, c0_rdata);
    end
  endtask

  task automatic test_write_c1();
    logic ok;
    wait_until(t0 + 20);
    c1_req = 1; c1_we = 1; c1_addr = 22'h3FFFFF; c1_ds = 2'b01; c1_din = 16'hA5A5;
    ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_din !== 16'hA5A5 || mem_ds !== 2'b01 ||
          mem_addr !== 22'h3FFFFF || c1_ack !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL write_slot: we=%b din=%h ds=%b required 1 a5a5 01", mem_we, mem_din, mem_ds); end
    tick();
    n_cmp++;
    if (c1_ack !== 1'b1 || mem_cs !== 1'b0 || mem_we !== 1'b0 || c1_rdata !== 16'h0 || c0_rdata !== 16'hBEEF) begin
      n_bad++; $display("FAIL write_ack: ack=%b cs=%b we=%b r1=%h r0=%h required 1 0 0 0000 beef",
                        c1_ack, mem_cs, mem_we, c1_rdata, c0_rdata);
    end
    c1_req = 0; c1_we = 0; c1_ds = 2'b11;
  endtask

  task automatic test_back_to_back();
    int slot, pos;
    logic e_cs, e0, e1;
    logic [ADDR_W-1:0] e_a;
    wait_until(t0 + 34);
    c0_req = 1; c0_we = 0; c0_addr = A0;
    c1_req = 1; c1_we = 0; c1_addr = A1;
    for (int i = 1; i <= 37; i++) begin
      tick();
      slot = (i - 1) / 9;
      pos  = (i - 1) % 9;
      e_cs = (slot < 4) && (pos < 8);
      e_a  = (slot % 2 == 0) ? A0 : A1;
      e0   = (i == 9) || (i == 27);
      e1   = (i == 18) || (i == 36);
      n_cmp++;
      if (mem_cs !== e_cs || (e_cs && mem_addr !== e_a) || c0_ack !== e0 || c1_ack !== e1 ||
          (e0 && c0_rdata !== 16'h9CBB) || (e1 && c1_rdata !== 16'h9F88)) begin
        n_bad++;
        $display("FAIL rr_cycle%0d: cs=%b addr=%h ack0=%b ack1=%b r0=%h r1=%h required cs=%b addr=%h ack0=%b ack1=%b",
                 i, mem_cs, mem_addr, c0_ack, c1_ack, c0_rdata, c1_rdata, e_cs, e_a, e0, e1);
      end
      if (i == 28) begin c0_req = 0; c1_req = 0; end
    end
  endtask

  task automatic test_refresh_in_slot();
    logic ok, seen;
    wait_until(t0 + 475);
    c0_req = 1; c0_addr = A0;
    c1_req = 1; c1_addr = A1;
    ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_cs !== 1'b1 || mem_refresh !== 1'b0 || mem_addr !== A0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ref_slot_completes: slot interrupted, addr=%h required %h", mem_addr, A0); end
    tick();
    n_cmp++;
    if (c0_ack !== 1'b1 || mem_cs !== 1'b0) begin
      n_bad++; $display("FAIL ref_slot_ack: ack0=%b cs=%b required 1 0", c0_ack, mem_cs);
    end
    c0_req = 0;
    tick();
    n_cmp++;
    if (mem_cs !== 1'b1 || mem_refresh !== 1'b1) begin
      n_bad++; $display("FAIL ref_pulse_next: cs=%b ref=%b required 1 1", mem_cs, mem_refresh);
    end
    ok = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (mem_cs !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ref_low_gap: cs high within 3 cycles after refresh, required 0"); end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (mem_cs === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || mem_refresh !== 1'b0 || mem_addr !== A1) begin
      n_bad++; $display("FAIL ref_then_client: seen=%b ref=%b addr=%h required 1 0 %h", seen, mem_refresh, mem_addr, A1);
    end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (c1_ack === 1'b1) seen = 1'b1;
    end
    c1_req = 0;
    n_cmp++;
    if (!seen || c1_rdata !== 16'h9F88) begin
      n_bad++; $display("FAIL ref_client_ack: seen=%b r1=%h required 1 9f88", seen, c1_rdata);
    end
  endtask

  task automatic test_reset_mid_slot();
    logic ok;
    repeat (3) tick();
    c0_req = 1; c0_we = 0; c0_addr = 22'h012345;
    repeat (4) tick();
    n_cmp++;
    if (mem_cs !== 1'b1) begin n_bad++; $display("FAIL rst_slot_active: cs=%b required 1", mem_cs); end
    reset_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (mem_cs !== 1'b0 || c0_ack !== 1'b0 || c0_rdata !== 16'h0) begin
      n_bad++; $display("FAIL rst_immediate: cs=%b ack=%b r0=%h required 0 0 0000", mem_cs, c0_ack, c0_rdata);
    end
    ok = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) reset_n = 1'b1;
      if (mem_cs !== 1'b0 || c0_ack !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_no_ack: cs or ack active before mem_ready, required 0"); end
    mem_ready = 1'b1;
    tick();
    n_cmp++;
    if (mem_cs !== 1'b0) begin n_bad++; $display("FAIL rst_idle: cs=%b required 0", mem_cs); end
    ok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_cs !== 1'b1 || mem_addr !== 22'h012345 || c0_ack !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_resume_slot: addr=%h cs=%b required 012345 1", mem_addr, mem_cs); end
    tick();
    n_cmp++;
    if (c0_ack !== 1'b1 || c0_rdata !== 16'hBEEF || mem_cs !== 1'b0) begin
      n_bad++; $display("FAIL rst_resume_ack: ack=%b r0=%h cs=%b required 1 beef 0", c0_ack, c0_rdata, mem_cs);
    end
    c0_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_refresh();
    test_read_c0();
    test_write_c1();
    test_back_to_back();
    test_refresh_in_slot();
    test_reset_mid_slot();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
